read_src_property_mt: RTL and testbench

READ_SRC_PROPERTY_MT -- requirements
Module: read_src_property_mt

---
 rtl/read_src_property_mt.sv | 123 ++++++++++++
 tb/tb_read_src_property_mt.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/read_src_property_mt.sv
// In-order source-property fetch stage. Each request is issued to DRAM and
// buffered with its payload; responses fill entries in request order, and the
// oldest filled entry is presented downstream.
module read_src_property_mt #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 32,
  parameter int PAYLOAD_W = 128,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_valid,
  input  logic [PAYLOAD_W-1:0]     i_payload,
  input  logic [ADDR_W-1:0]        i_src_addr,
  output logic                     p_stall_can_accept,
  output logic                     mem_req_valid,
  output logic [ADDR_W-1:0]        mem_req_addr,
  input  logic                     mem_req_ready,
  input  logic                     mem_rsp_valid,
  input  logic [DATA_W-1:0]        mem_rsp_data,
  output logic                     o_valid,
  output logic [PAYLOAD_W-1:0]     o_payload,
  output logic [DATA_W-1:0]        o_src_data,
  input  logic                     n_stall_can_accept,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err_unexpected_rsp
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rsp_ptr_q, rsp_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        out_q, out_d;    // allocated, not retired
  logic [CW-1:0]        pend_q, pend_d;  // allocated, not filled: [rsp_ptr, wr_ptr)
  logic [DEPTH-1:0]     filled_q, filled_d;
  logic                 err_q, err_d;
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  logic [PAYLOAD_W-1:0] payload_d [DEPTH];
  logic [DATA_W-1:0]    data_q [DEPTH];
  logic [DATA_W-1:0]    data_d [DEPTH];

  logic room, alloc, fill, retire;

  // Handshakes, buffer updates and counters for allocate / fill / retire
  always_comb begin
    // reset_n gates the request side so nothing looks acceptable while held in reset
    room               = reset_n && (out_q != FULL);
    mem_req_valid      = i_valid & room;
    mem_req_addr       = i_src_addr;
    p_stall_can_accept = mem_req_ready & room;
    alloc              = i_valid & p_stall_can_accept;
    // Fill decisions use the registered pending count, so a word can never
    // land in an entry allocated in the same cycle or in one being retired.
    fill               = mem_rsp_valid & (pend_q != '0);
    o_valid            = filled_q[rd_ptr_q] & (out_q != '0);
    o_payload          = payload_q[rd_ptr_q];
    o_src_data         = data_q[rd_ptr_q];
    retire             = o_valid & n_stall_can_accept;
    outstanding        = out_q;
    err_unexpected_rsp = err_q;

    wr_ptr_d  = wr_ptr_q;
    rsp_ptr_d = rsp_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    filled_d  = filled_q;
    payload_d = payload_q;
    data_d    = data_q;
    err_d     = err_q | (mem_rsp_valid & ~fill);

    if (retire) begin
      filled_d[rd_ptr_q] = 1'b0;
      rd_ptr_d           = rd_ptr_q + 1'b1;
    end
    if (alloc) begin
      payload_d[wr_ptr_q] = i_payload;
      filled_d[wr_ptr_q]  = 1'b0;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (fill) begin
      data_d[rsp_ptr_q]   = mem_rsp_data;
      filled_d[rsp_ptr_q] = 1'b1;
      rsp_ptr_d           = rsp_ptr_q + 1'b1;
    end

    case ({alloc, retire})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
    case ({alloc, fill})
      2'b10:   pend_d = pend_q + 1'b1;
      2'b01:   pend_d = pend_q - 1'b1;
      default: pend_d = pend_q;
    endcase
  end

  // Control state: pointers, counters, flags; cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rsp_ptr_q <= '0;
      rd_ptr_q  <= '0;
      out_q     <= '0;
      pend_q    <= '0;
      filled_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rsp_ptr_q <= rsp_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      out_q     <= out_d;
      pend_q    <= pend_d;
      filled_q  <= filled_d;
      err_q     <= err_d;
    end
  end

  // Payload/data storage; contents are only observed behind a filled flag
  always_ff @(posedge clk) begin
    payload_q <= payload_d;
    data_q    <= data_d;
  end
endmodule

// File: tb/tb_read_src_property_mt.sv
// Randomized + directed bench; expected behaviour comes from a queue model of
// the in-order buffer (one queue element per outstanding request).
module tb_read_src_property_mt;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_valid;
  logic [127:0]  i_payload;
  logic [31:0]   i_src_addr;
  logic          p_stall_can_accept, mem_req_valid, mem_req_ready;
  logic [31:0]   mem_req_addr;
  logic          mem_rsp_valid;
  logic [63:0]   mem_rsp_data;
  logic          o_valid;
  logic [127:0]  o_payload;
  logic [63:0]   o_src_data;
  logic          n_stall_can_accept;
  logic [2:0]    outstanding;
  logic          err_unexpected_rsp;

  read_src_property_mt #(.DATA_W(64), .ADDR_W(32), .PAYLOAD_W(128), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_payload(i_payload),
    .i_src_addr(i_src_addr), .p_stall_can_accept(p_stall_can_accept),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .o_valid(o_valid), .o_payload(o_payload),
    .o_src_data(o_src_data), .n_stall_can_accept(n_stall_can_accept),
    .outstanding(outstanding), .err_unexpected_rsp(err_unexpected_rsp)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // reference model: one element per allocated, not yet retired request
  logic [127:0] m_pl[$];
  logic [63:0]  m_d[$];
  bit           m_f[$];
  bit           m_err = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int pending();
    int p = 0;
    foreach (m_f[i]) if (!m_f[i]) p++;
    return p;
  endfunction

  task automatic model_clear();
    m_pl.delete(); m_d.delete(); m_f.delete(); m_err = 1'b0;
  endtask

  // Drive one cycle of inputs (called at posedge+1), check outputs, advance model
  task automatic step(input bit iv, input logic [127:0] pl, input logic [31:0] ad,
                      input bit rdy, input bit rv, input logic [63:0] rd, input bit nst);
    int sz, fi;
    bit room, ev;
    i_valid = iv; i_payload = pl; i_src_addr = ad; mem_req_ready = rdy;
    mem_rsp_valid = rv; mem_rsp_data = rd; n_stall_can_accept = nst;
    #2;
    sz = m_pl.size();
    room = sz < DEPTH;
    ev = (sz > 0) && m_f[0];
    fi = -1;
    for (int i = 0; i < sz; i++) if (!m_f[i] && fi < 0) fi = i;
    chk("outstanding", outstanding, sz);
    chk("mem_req_valid", mem_req_valid, iv && room);
    chk("p_stall_can_accept", p_stall_can_accept, rdy && room);
    chk("mem_req_addr", mem_req_addr, ad);
    chk("o_valid", o_valid, ev);
    chk("err", err_unexpected_rsp, m_err);
    if (ev) begin
      chk("o_payload", o_payload, m_pl[0]);
      chk("o_src_data", o_src_data, m_d[0]);
    end
    @(posedge clk);
    if (rv) begin
      if (fi >= 0) begin m_d[fi] = rd; m_f[fi] = 1'b1; end
      else m_err = 1'b1;
    end
    if (ev && nst) begin void'(m_pl.pop_front()); void'(m_d.pop_front()); void'(m_f.pop_front()); end
    if (iv && rdy && room) begin m_pl.push_back(pl); m_d.push_back('0); m_f.push_back(1'b0); end
    #1;
  endtask

  task automatic idle(input bit rv, input logic [63:0] rd, input bit nst);
    step(1'b0, 128'h0, 32'h0, 1'b1, rv, rd, nst);
  endtask

  initial begin
    reset_n = 1'b0; i_valid = 1'b1; i_payload = '0; i_src_addr = '0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0; n_stall_can_accept = 1'b1;
    #3;
    chk("rst_o_valid", o_valid, 1'b0);
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_p_stall", p_stall_can_accept, 1'b0);
    chk("rst_outstanding", outstanding, 3'd0);
    chk("rst_err", err_unexpected_rsp, 1'b0);
    i_valid = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;

    // single request, response two cycles later, retire
    step(1'b1, 128'hA5, 32'h100, 1'b1, 1'b0, 64'h0, 1'b1);
    idle(1'b0, 64'h0, 1'b1);
    idle(1'b1, 64'hDEAD, 1'b1);
    chk("single_o_valid", o_valid, 1'b1);
    chk("single_o_payload", o_payload, 128'hA5);
    chk("single_o_data", o_src_data, 64'hDEAD);
    idle(1'b0, 64'h0, 1'b1);
    chk("single_retired", outstanding, 3'd0);

    // fill to full: five back-to-back requests, four accepted
    for (int i = 0; i < 5; i++) step(1'b1, 128'(i + 16), 32'(i * 8), 1'b1, 1'b0, 64'h0, 1'b0);
    chk("full_outstanding", outstanding, 3'd4);
    // responses D0..D3 under downstream stall, then drain in order
    for (int i = 0; i < 4; i++) idle(1'b1, 64'(64'hD0 + i), 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b0, 64'h0, 1'b0);
    // full with oldest filled, i_valid held: retire first, then retire+allocate
    for (int i = 0; i < 4; i++) step(1'b1, 128'(i + 32), 32'(i), 1'b1, 1'b0, 64'h0, 1'b1);
    for (int i = 0; i < 12; i++) idle(pending() > 0, 64'(i + 64'hE0), 1'b1);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      step(($urandom % 10) < 7, {$urandom, $urandom, $urandom, $urandom}, $urandom,
           ($urandom % 4) != 0, (pending() > 0) && ($urandom % 2 == 1),
           {$urandom, $urandom}, ($urandom % 5) < 3);
    end
    for (int i = 0; i < 16; i++) idle(pending() > 0, 64'(i), 1'b1);
    chk("drained", outstanding, 3'd0);

    // unexpected response: sticky error, no output
    idle(1'b1, 64'hBAD, 1'b1);
    idle(1'b0, 64'h0, 1'b1);
    idle(1'b0, 64'h0, 1'b1);
    #2 reset_n = 1'b0;
    #1 chk("err_cleared", err_unexpected_rsp, 1'b0);
    @(posedge clk); #1 reset_n = 1'b1;
    model_clear();

    // reset mid-flight with 3 outstanding, then late responses
    for (int i = 0; i < 3; i++) step(1'b1, 128'(i + 48), 32'(i), 1'b1, 1'b0, 64'h0, 1'b0);
    idle(1'b1, 64'h77, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_outstanding", outstanding, 3'd0);
    chk("mid_rst_o_valid", o_valid, 1'b0);
    @(posedge clk); #1 reset_n = 1'b1;
    model_clear();
    idle(1'b1, 64'h88, 1'b1);
    idle(1'b1, 64'h99, 1'b1);
    idle(1'b0, 64'h0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
